uart_tx_buffered: RTL

Downstream stage of the sensor crossbar. It accepts the ASCII bytes the crossbar emits, one per cycle, and queues them in a small FIFO. It serializes them LSB-first as 8N1 UART frames on the board TX pin. Because of the FIFO, the crossbar's 5- or 8-byte bursts never stall on the baud-rate transmitter.

---
 rtl/uart_tx_buffered.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 UART transmitter.
// Bytes written one per cycle are queued and sent LSB-first on tx_serial.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit (8E1 frames).

module uart_tx_buffered #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_overflow,
  output logic                          tx_serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      sh;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx, bit_idx_next;
  logic            wr_en, pop, bit_done, serial_next;

  assign tx_ready   = !rst && (count < DEPTH);
  assign wr_en      = tx_valid && tx_ready;
  assign bit_done   = (baud_cnt == BAUD_LAST);
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  // Next-state logic; the line level for the next state is precomputed so tx_serial can be registered
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    bit_idx_next = bit_idx;
    serial_next  = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (count != '0) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = sh[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_next = ^sh;
`endif
      default: serial_next = 1'b1;
    endcase
  end

  // FSM state, baud and bit counters, registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      tx_serial <= 1'b1;
    end else begin
      state     <= state_next;
      bit_idx   <= bit_idx_next;
      tx_serial <= serial_next;
      if (state_next != state || state_next == IDLE || bit_done)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // FIFO pointers, occupancy, shift-register load on pop and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sh          <= 8'h00;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        sh     <= mem[rd_ptr];
      end
      count       <= count + CW'(wr_en) - CW'(pop);
      tx_overflow <= tx_valid && !tx_ready;
    end
  end

  // FIFO storage; no reset needed since occupancy guards every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= tx_data;
  end

endmodule
